// File: rtl/dla_debug_network_csr_bridge.sv
// CSR-to-debug-network read bridge: one outstanding AR/R read, status and data cached for the runtime.
// Optional response timeout is compiled in with `define DLA_DEBUG_NETWORK_BRIDGE_TIMEOUT_EN.
module dla_debug_network_csr_bridge #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  i_resetn_async,

   input  logic                  i_req_valid,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic                  i_clear,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_timeout,
   output logic [DATA_WIDTH-1:0] o_rdata,

   output logic                  o_dbg_arvalid,
   output logic [ADDR_WIDTH-1:0] o_dbg_araddr,
   input  logic                  i_dbg_arready,
   input  logic                  i_dbg_rvalid,
   input  logic [DATA_WIDTH-1:0] i_dbg_rdata,
   output logic                  o_dbg_rready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_TOUT
   } state_e;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << 20)) begin : g_param_check
      $error("TIMEOUT_CYCLES must lie in 2..2^20");
   end

   // Reset asserts asynchronously but releases on a clock edge, so no flop sees a runt release.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge i_resetn_async) begin
      if (!i_resetn_async) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

`ifdef DLA_DEBUG_NETWORK_BRIDGE_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
`endif

   state_e                state_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  timeout_q;
   logic                  arvalid_q;
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
   // NOTE: the data/address registers are reset too, so software never reads X after power-up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         rdata_q   <= '0;
`ifdef DLA_DEBUG_NETWORK_BRIDGE_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else if (i_req_valid) begin
         // A new CSR write wins over everything else; any in-flight read is abandoned.
         state_q   <= S_ISSUE;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         arvalid_q <= 1'b1;
         araddr_q  <= i_req_addr;
      end else begin
         case (state_q)
            S_IDLE: begin
            end

            S_ISSUE: begin
               if (i_dbg_arready) begin
                  state_q   <= S_WAIT;
                  arvalid_q <= 1'b0;
`ifdef DLA_DEBUG_NETWORK_BRIDGE_TIMEOUT_EN
                  cnt_q     <= CNT_LOAD;
`endif
               end
            end

            S_WAIT: begin
               if (i_dbg_rvalid) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  rdata_q <= i_dbg_rdata;
`ifdef DLA_DEBUG_NETWORK_BRIDGE_TIMEOUT_EN
               end else if (cnt_q == '0) begin
                  state_q   <= S_TOUT;
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
`endif
               end
            end

            S_DONE, S_TOUT: begin
               if (i_clear) begin
                  state_q   <= S_IDLE;
                  done_q    <= 1'b0;
                  timeout_q <= 1'b0;
               end
            end

            default: begin
               state_q   <= S_IDLE;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
               timeout_q <= 1'b0;
               arvalid_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy        = busy_q;
   assign o_done        = done_q;
`ifdef DLA_DEBUG_NETWORK_BRIDGE_TIMEOUT_EN
   assign o_timeout     = timeout_q;
`else
   assign o_timeout     = 1'b0;
`endif
   assign o_rdata       = rdata_q;
   assign o_dbg_arvalid = arvalid_q;
   assign o_dbg_araddr  = araddr_q;
   assign o_dbg_rready  = 1'b1;

`ifndef DLA_DEBUG_NETWORK_BRIDGE_TIMEOUT_EN
   logic unused_timeout;
   assign unused_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_dla_debug_network_csr_bridge.sv
// Self-checking bench for dla_debug_network_csr_bridge: cycle table plus stall, timeout and reset sequences.
// Expectations follow the build: timeout checks when DLA_DEBUG_NETWORK_BRIDGE_TIMEOUT_EN is defined.
module tb_dla_debug_network_csr_bridge;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          req_valid = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic          clr = 1'b0;
   logic          busy, done, tout;
   logic [DW-1:0] rdata;
   logic          arvalid;
   logic [AW-1:0] araddr;
   logic          arready = 1'b0;
   logic          rvalid = 1'b0;
   logic [DW-1:0] rdata_in = '0;
   logic          rready;

   dla_debug_network_csr_bridge #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk           (clk),
      .i_resetn_async(rstn),
      .i_req_valid   (req_valid),
      .i_req_addr    (req_addr),
      .i_clear       (clr),
      .o_busy        (busy),
      .o_done        (done),
      .o_timeout     (tout),
      .o_rdata       (rdata),
      .o_dbg_arvalid (arvalid),
      .o_dbg_araddr  (araddr),
      .i_dbg_arready (arready),
      .i_dbg_rvalid  (rvalid),
      .i_dbg_rdata   (rdata_in),
      .o_dbg_rready  (rready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          req;
      logic [AW-1:0] addr;
      logic          clr;
      logic          ard;
      logic          rv;
      logic [DW-1:0] rd;
      logic          e_busy;
      logic          e_done;
      logic          e_arv;
      logic [AW-1:0] e_araddr;
      logic [DW-1:0] e_rdata;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic check_all(input string tag, input logic e_busy, input logic e_done,
                            input logic e_tout, input logic e_arv,
                            input logic [AW-1:0] e_araddr, input logic [DW-1:0] e_rdata);
      check({tag, ".busy"},    32'(busy),    32'(e_busy));
      check({tag, ".done"},    32'(done),    32'(e_done));
      check({tag, ".timeout"}, 32'(tout),    32'(e_tout));
      check({tag, ".arvalid"}, 32'(arvalid), 32'(e_arv));
      check({tag, ".araddr"},  araddr,       e_araddr);
      check({tag, ".rdata"},   rdata,        e_rdata);
      check({tag, ".rready"},  32'(rready),  32'd1);
   endtask

   task automatic drive(input logic r, input logic [AW-1:0] a, input logic c,
                        input logic ard, input logic rv, input logic [DW-1:0] rd);
      @(negedge clk);
      req_valid = r;
      req_addr  = a;
      clr       = c;
      arready   = ard;
      rvalid    = rv;
      rdata_in  = rd;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic r, logic [AW-1:0] a, logic c, logic ard, logic rv,
                               logic [DW-1:0] rd, logic eb, logic ed, logic ea,
                               logic [AW-1:0] eaddr, logic [DW-1:0] erd);
      vec_t v;
      v.req = r; v.addr = a; v.clr = c; v.ard = ard; v.rv = rv; v.rd = rd;
      v.e_busy = eb; v.e_done = ed; v.e_arv = ea; v.e_araddr = eaddr; v.e_rdata = erd;
      return v;
   endfunction

   vec_t vecs[21];

   initial begin
      //            req addr          clr ard rv rdata          busy done arv araddr        rdata
      vecs[0]  = mk(1, 32'h0300_0010, 0, 0, 0, 32'h0,          1, 0, 1, 32'h0300_0010, 32'h0);
      vecs[1]  = mk(0, 32'h0,         0, 1, 0, 32'h0,          1, 0, 0, 32'h0300_0010, 32'h0);
      vecs[2]  = mk(0, 32'h0,         0, 0, 0, 32'h0,          1, 0, 0, 32'h0300_0010, 32'h0);
      vecs[3]  = mk(0, 32'h0,         0, 0, 0, 32'h0,          1, 0, 0, 32'h0300_0010, 32'h0);
      vecs[4]  = mk(0, 32'h0,         0, 0, 0, 32'h0,          1, 0, 0, 32'h0300_0010, 32'h0);
      vecs[5]  = mk(0, 32'h0,         0, 0, 0, 32'h0,          1, 0, 0, 32'h0300_0010, 32'h0);
      vecs[6]  = mk(0, 32'h0,         0, 0, 1, 32'hDEAD_BEEF,  0, 1, 0, 32'h0300_0010, 32'hDEAD_BEEF);
      vecs[7]  = mk(0, 32'h0,         0, 0, 1, 32'h1111_1111,  0, 1, 0, 32'h0300_0010, 32'hDEAD_BEEF);
      vecs[8]  = mk(0, 32'h0,         1, 0, 0, 32'h0,          0, 0, 0, 32'h0300_0010, 32'hDEAD_BEEF);
      vecs[9]  = mk(0, 32'h0,         1, 0, 0, 32'h0,          0, 0, 0, 32'h0300_0010, 32'hDEAD_BEEF);
      vecs[10] = mk(1, 32'h0000_0040, 0, 0, 0, 32'h0,          1, 0, 1, 32'h0000_0040, 32'hDEAD_BEEF);
      vecs[11] = mk(0, 32'h0,         0, 1, 0, 32'h0,          1, 0, 0, 32'h0000_0040, 32'hDEAD_BEEF);
      vecs[12] = mk(0, 32'h0,         1, 0, 0, 32'h0,          1, 0, 0, 32'h0000_0040, 32'hDEAD_BEEF);
      vecs[13] = mk(1, 32'h0100_0004, 0, 0, 1, 32'h0000_0055,  1, 0, 1, 32'h0100_0004, 32'hDEAD_BEEF);
      vecs[14] = mk(0, 32'h0,         0, 0, 1, 32'h0000_0066,  1, 0, 1, 32'h0100_0004, 32'hDEAD_BEEF);
      vecs[15] = mk(0, 32'h0,         0, 1, 0, 32'h0,          1, 0, 0, 32'h0100_0004, 32'hDEAD_BEEF);
      vecs[16] = mk(0, 32'h0,         0, 0, 1, 32'h00C0_FFEE,  0, 1, 0, 32'h0100_0004, 32'h00C0_FFEE);
      vecs[17] = mk(1, 32'h0000_2000, 0, 0, 0, 32'h0,          1, 0, 1, 32'h0000_2000, 32'h00C0_FFEE);
      vecs[18] = mk(0, 32'h0,         0, 1, 0, 32'h0,          1, 0, 0, 32'h0000_2000, 32'h00C0_FFEE);
      vecs[19] = mk(0, 32'h0,         0, 0, 1, 32'hA5A5_A5A5,  0, 1, 0, 32'h0000_2000, 32'hA5A5_A5A5);
      vecs[20] = mk(0, 32'h0,         1, 0, 0, 32'h0,          0, 0, 0, 32'h0000_2000, 32'hA5A5_A5A5);

      // Reset and its synchronous release.
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all("in_reset", 0, 0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all("after_reset", 0, 0, 0, 0, 32'h0, 32'h0);

      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].req, vecs[i].addr, vecs[i].clr, vecs[i].ard, vecs[i].rv, vecs[i].rd);
         check_all($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_done, 1'b0,
                   vecs[i].e_arv, vecs[i].e_araddr, vecs[i].e_rdata);
      end

      // Stalled address handshake, then the response wait.
      drive(1, 32'h1234_5678, 0, 0, 0, 32'h0);
      for (int k = 0; k < 10; k++) begin
         drive(0, 32'h0, 0, 0, 0, 32'h0);
         check_all($sformatf("stall%0d", k), 1, 0, 0, 1, 32'h1234_5678, 32'hA5A5_A5A5);
      end
      drive(0, 32'h0, 0, 1, 0, 32'h0);
      check_all("stall_hs", 1, 0, 0, 0, 32'h1234_5678, 32'hA5A5_A5A5);
`ifdef DLA_DEBUG_NETWORK_BRIDGE_TIMEOUT_EN
      for (int k = 1; k <= TO; k++) begin
         drive(0, 32'h0, 0, 0, 0, 32'h0);
         check_all($sformatf("tout_wait%0d", k), (k != TO), 0, (k == TO), 0,
                   32'h1234_5678, 32'hA5A5_A5A5);
      end
      drive(0, 32'h0, 0, 0, 1, 32'h0000_1234);
      check_all("late_rvalid", 0, 0, 1, 0, 32'h1234_5678, 32'hA5A5_A5A5);
      drive(0, 32'h0, 1, 0, 0, 32'h0);
      check_all("tout_clear", 0, 0, 0, 0, 32'h1234_5678, 32'hA5A5_A5A5);

      // Response arriving on the expiry cycle wins.
      drive(1, 32'h0000_0800, 0, 0, 0, 32'h0);
      drive(0, 32'h0, 0, 1, 0, 32'h0);
      for (int k = 1; k < TO; k++) drive(0, 32'h0, 0, 0, 0, 32'h0);
      check_all("edge_pre", 1, 0, 0, 0, 32'h0000_0800, 32'hA5A5_A5A5);
      drive(0, 32'h0, 0, 0, 1, 32'h0BAD_CAFE);
      check_all("edge_rvalid", 0, 1, 0, 0, 32'h0000_0800, 32'h0BAD_CAFE);
      drive(0, 32'h0, 1, 0, 0, 32'h0);
      check_all("edge_clear", 0, 0, 0, 0, 32'h0000_0800, 32'h0BAD_CAFE);
`else
      for (int k = 1; k <= TO + 4; k++) begin
         drive(0, 32'h0, 0, 0, 0, 32'h0);
         check_all($sformatf("no_tout%0d", k), 1, 0, 0, 0, 32'h1234_5678, 32'hA5A5_A5A5);
      end
      drive(0, 32'h0, 0, 0, 1, 32'h0000_1234);
      check_all("late_rvalid", 0, 1, 0, 0, 32'h1234_5678, 32'h0000_1234);
      drive(0, 32'h0, 1, 0, 0, 32'h0);
      check_all("late_clear", 0, 0, 0, 0, 32'h1234_5678, 32'h0000_1234);
`endif

      // Reset in the middle of WAIT, then a stale response.
      drive(1, 32'h0000_0044, 0, 0, 0, 32'h0);
      drive(0, 32'h0, 0, 1, 0, 32'h0);
      drive(0, 32'h0, 0, 0, 0, 32'h0);
      check_all("pre_rst", 1, 0, 0, 0, 32'h0000_0044, rdata);
      rstn = 1'b0;
      #1;
      check_all("rst_async", 0, 0, 0, 0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      drive(0, 32'h0, 0, 0, 1, 32'h0000_0077);
      check_all("post_rst_rvalid", 0, 0, 0, 0, 32'h0, 32'h0);
      drive(0, 32'h0, 0, 0, 0, 32'h0);
      check_all("post_rst_idle", 0, 0, 0, 0, 32'h0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dla_debug_network_csr_bridge.md
DLA_DEBUG_NETWORK_CSR_BRIDGE -- requirements
Module: dla_debug_network_csr_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the read response data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: width of the debug network read address.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: number of WAIT-state cycles before a timeout (legal range 2..2^20).
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port i_resetn_async, input, 1: asynchronous active-low reset, not synchronized to any clock.
REQ-006 SHALL have port i_req_valid, input, 1: a one-cycle pulse when the runtime writes the address CSR.
REQ-007 SHALL have port i_req_addr, input, ADDR_WIDTH: the address written by the runtime.
REQ-008 SHALL have port i_clear, input, 1: a one-cycle pulse that clears done/timeout status.
REQ-009 SHALL have port o_busy, output, 1: a transaction is in flight (ISSUE or WAIT).
REQ-010 SHALL have port o_done, output, 1: o_rdata holds a response for the most recent request.
REQ-011 SHALL have port o_timeout, output, 1: the most recent request timed out.
REQ-012 SHALL have port o_rdata, output, DATA_WIDTH: the cached response data.
REQ-013 SHALL have port o_dbg_arvalid, output, 1: read address valid, driven to the debug network.
REQ-014 SHALL have port o_dbg_araddr, output, ADDR_WIDTH: read address to the debug network.
REQ-015 SHALL have port i_dbg_arready, input, 1: read address ready from the debug network.
REQ-016 SHALL have port i_dbg_rvalid, input, 1: read response valid from the debug network.
REQ-017 SHALL have port i_dbg_rdata, input, DATA_WIDTH: read response data from the debug network.
REQ-018 SHALL have port o_dbg_rready, output, 1: read response ready; tied to 1.

Function
REQ-019 SHALL implement a state machine with states IDLE, ISSUE, WAIT, DONE and TOUT.
REQ-020 SHALL, in any state, on i_req_valid: register i_req_addr into o_dbg_araddr, enter ISSUE next cycle, and clear o_done and o_timeout; any in-flight transaction is abandoned.
REQ-021 SHALL, in ISSUE, assert o_dbg_arvalid with a stable address; on arvalid&arready, go to WAIT and load the timeout counter with TIMEOUT_CYCLES-1.
REQ-022 SHALL, in WAIT, on i_dbg_rvalid: capture i_dbg_rdata into o_rdata, assert o_done next cycle, and enter DONE.
REQ-023 SHALL, in WAIT, decrement the counter each cycle without a response; on reaching 0 with no rvalid, enter TOUT and assert o_timeout.
REQ-024 SHALL give rvalid priority over expiry when both occur in the same cycle (enter DONE).
REQ-025 SHALL give i_req_valid priority over rvalid, expiry and i_clear in the same cycle; the response is then dropped.
REQ-026 SHALL discard i_dbg_rvalid in IDLE, ISSUE, DONE and TOUT, leaving o_rdata unchanged (stale or spurious responses).
REQ-027 SHALL, on i_clear in DONE or TOUT, return to IDLE and deassert o_done/o_timeout; o_rdata is retained; i_clear in other states is ignored.
REQ-028 SHALL assert o_busy exactly in ISSUE and WAIT; o_done and o_timeout SHALL never be high together.
REQ-029 SHALL produce latency req pulse -> arvalid = 1 cycle; rvalid -> o_done = 1 cycle.

Reset
REQ-030 SHALL synchronize i_resetn_async internally (assert asynchronously, deassert synchronously) before use.
REQ-031 SHALL, during reset, hold state at IDLE with o_busy, o_done, o_timeout and o_dbg_arvalid at 0, o_rdata at 0, o_dbg_araddr at 0 and the counter at 0.
REQ-032 SHALL, on reset mid-transaction, abandon the transaction; a later response is discarded per REQ-026.

Configuration
REQ-033 SHALL, when macro DLA_DEBUG_NETWORK_BRIDGE_TIMEOUT_EN is defined, include the timeout counter and TOUT behaviour.
REQ-034 SHALL, when the macro is undefined, have no counter: WAIT persists until rvalid, a new request or reset, and o_timeout is tied to 0.

Verification
REQ-035 SHALL cover: req addr 0x0300_0010; arready=1; rvalid with 0xDEADBEEF after 5 cycles -> o_done=1 and o_rdata=0xDEADBEEF one cycle later, o_busy=0.
REQ-036 SHALL cover: arready held low 10 cycles -> arvalid and araddr stable throughout; the counter does not run until the handshake.
REQ-037 SHALL cover (TIMEOUT_EN, TIMEOUT_CYCLES=8): no response -> o_timeout=1 exactly 8 cycles after the handshake; a late rvalid 0x1234 is then ignored and o_rdata is unchanged.
REQ-038 SHALL cover: new req 0x0100_0004 in the same cycle as rvalid 0x55 in WAIT -> response dropped, ISSUE with the new address, o_done=0.
REQ-039 SHALL cover: i_resetn_async low during WAIT -> all status outputs 0 immediately; rvalid after reset release -> no o_done.
REQ-040 SHALL cover: i_clear in DONE -> IDLE with o_done=0 and o_rdata retained; i_clear in WAIT -> no effect.
